// File: rtl/axi_stream_pipeline_pkg.sv
// Shared types and constants for the RGB frame pipeline: beat widths,
// header FSM states and the beat record carried through the register slices.
package axi_stream_pipeline_pkg;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned DIM_W  = 13;
    localparam int unsigned CNT_W  = 2 * DIM_W;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [DIM_W-1:0] dim_t;

    typedef enum logic [1:0] {
        HDR_X,
        HDR_Y,
        PIX
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

endpackage

// File: rtl/axi_stream_pipeline_if.sv
// AXI4-Stream beat bundle; master drives valid/last/data, slave drives ready.
interface axi_stream_pipeline_if;
    import axi_stream_pipeline_pkg::*;

    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DATA_W-1:0] tdata;

    modport master (output tvalid, output tlast, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tdata, output tready);

endinterface

// File: rtl/axi_stream_pipeline_reg_stage.sv
// One valid/ready register slice with a skid buffer: ready is a pure flop,
// so a stalled output never combinationally blocks the upstream stage.
module axis_reg_stage
    import axi_stream_pipeline_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  s_valid_i,
    output logic  s_ready_o,
    input  beat_t s_beat_i,
    output logic  m_valid_o,
    input  logic  m_ready_i,
    output beat_t m_beat_o
);

    logic  out_valid_q, out_valid_d;
    beat_t out_beat_q, out_beat_d;
    logic  skid_valid_q, skid_valid_d;
    beat_t skid_beat_q, skid_beat_d;
    logic  s_acc;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_beat_d   = out_beat_q;
        skid_valid_d = skid_valid_q;
        skid_beat_d  = skid_beat_q;
        s_acc        = s_valid_i && !skid_valid_q;

        if (!out_valid_q || m_ready_i) begin
            // Output slot frees up: a parked skid beat always goes first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_beat_d   = skid_beat_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = s_acc;
                if (s_acc) begin
                    out_beat_d = s_beat_i;
                end
            end
        end else if (s_acc) begin
            skid_valid_d = 1'b1;
            skid_beat_d  = s_beat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            out_beat_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_beat_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_beat_q   <= out_beat_d;
            skid_valid_q <= skid_valid_d;
            skid_beat_q  <= skid_beat_d;
        end
    end

    assign s_ready_o = !skid_valid_q;
    assign m_valid_o = out_valid_q;
    assign m_beat_o  = out_beat_q;

endmodule

// File: rtl/axi_stream_pipeline.sv
// Frame pipeline: consumes the Xsize/Ysize header, tags the final pixel with
// last, and pushes pixels through a chain of PIPE_STAGES register slices.
module axi_stream_pipeline
    import axi_stream_pipeline_pkg::*;
#(
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    axi_stream_pipeline_if.slave         s_axis,
    axi_stream_pipeline_if.master        m_axis
);

    state_t state_q, state_d;
    dim_t   x_q, x_d;
    cnt_t   total_q, total_d;
    cnt_t   cnt_q, cnt_d;
    logic   en_q;

    logic   tready;
    logic   in_xfer;
    logic   pix_last;
    dim_t   hdr_dim;
    logic   unused_tlast;

    logic [PIPE_STAGES:0] v;
    logic [PIPE_STAGES:0] r;
    beat_t                b [PIPE_STAGES+1];

    // Framing comes only from the header; upstream tlast carries no meaning here.
    assign unused_tlast = s_axis.tlast;

    assign tready   = en_q && r[0];
    assign in_xfer  = s_axis.tvalid && tready;
    assign hdr_dim  = s_axis.tdata[DIM_W-1:0];
    assign pix_last = (cnt_q == (total_q - cnt_t'(1)));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        total_d = total_q;
        cnt_d   = cnt_q;

        case (state_q)
            HDR_X: begin
                if (in_xfer) begin
                    x_d     = hdr_dim;
                    state_d = HDR_Y;
                end
            end
            HDR_Y: begin
                if (in_xfer) begin
                    total_d = cnt_t'(x_q) * cnt_t'(hdr_dim);
                    cnt_d   = '0;
                    state_d = (total_d == '0) ? HDR_X : PIX;
                end
            end
            PIX: begin
                if (in_xfer) begin
                    if (pix_last) begin
                        cnt_d   = '0;
                        state_d = HDR_X;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
            end
            default: state_d = HDR_X;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= HDR_X;
            x_q     <= '0;
            total_q <= '0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            total_q <= total_d;
            cnt_q   <= cnt_d;
            en_q    <= 1'b1;
        end
    end

    assign v[0]         = s_axis.tvalid && en_q && (state_q == PIX);
    assign b[0].data    = s_axis.tdata;
    assign b[0].last    = pix_last;
    assign r[PIPE_STAGES] = m_axis.tready;

    for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
        axis_reg_stage u_stage (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .s_valid_i (v[i]),
            .s_ready_o (r[i]),
            .s_beat_i  (b[i]),
            .m_valid_o (v[i+1]),
            .m_ready_i (r[i+1]),
            .m_beat_o  (b[i+1])
        );
    end

    assign s_axis.tready = tready;
    assign m_axis.tvalid = v[PIPE_STAGES];
    assign m_axis.tdata  = b[PIPE_STAGES].data;
    assign m_axis.tlast  = b[PIPE_STAGES].last;

endmodule

// File: tb/tb_axi_stream_pipeline.sv
// Scoreboard bench: the driver queues each accepted pixel with its expected
// last flag (from Xsize*Ysize), and an independent monitor pops and compares.
module tb_axi_stream_pipeline;
    import axi_stream_pipeline_pkg::*;

    localparam int unsigned STAGES = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_stream_pipeline_if s_if();
    axi_stream_pipeline_if m_if();

    axi_stream_pipeline #(.PIPE_STAGES(STAGES)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .s_axis (s_if),
        .m_axis (m_if)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int mode    = 0;

    logic [DATA_W:0] exp_q [$];
    logic [DATA_W:0] mon_e;
    logic [DATA_W:0] hold_val;
    bit              hold_pending = 0;
    bit              chk_rdy      = 0;
    bit              lat_req      = 0;
    bit              lat_armed    = 0;
    int              first_acc_cyc = 0;
    int              first_out_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: m_if.tready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (hold_pending && !rst) begin
                vectors++;
                if (!m_if.tvalid || ({m_if.tlast, m_if.tdata} !== hold_val)) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b beat=%h required valid=1 beat=%h",
                             m_if.tvalid, {m_if.tlast, m_if.tdata}, hold_val);
                end
            end
            hold_pending = m_if.tvalid && !m_if.tready && !rst;
            if (hold_pending) hold_val = {m_if.tlast, m_if.tdata};

            if (chk_rdy) begin
                vectors++;
                if (s_if.tready !== 1'b1) begin
                    errors++;
                    $display("FAIL sustained_ready: got tready_o=%b required 1 at cycle %0d", s_if.tready, cyc);
                end
            end

            if (lat_armed && m_if.tvalid) begin
                first_out_cyc = cyc;
                lat_armed = 0;
            end

            if (m_if.tvalid && m_if.tready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got data=%h last=%b required no output",
                             m_if.tdata, m_if.tlast);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (m_if.tdata !== mon_e[DATA_W-1:0]) begin
                        errors++;
                        $display("FAIL out_data: got %h required %h", m_if.tdata, mon_e[DATA_W-1:0]);
                    end
                    vectors++;
                    if (m_if.tlast !== mon_e[DATA_W]) begin
                        errors++;
                        $display("FAIL out_last: got %b required %b for data %h",
                                 m_if.tlast, mon_e[DATA_W], mon_e[DATA_W-1:0]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        vectors++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input bit is_pix, input bit last, input bit gaps);
        bit acc;
        int budget;
        if (gaps && ($urandom_range(0, 3) == 0)) begin
            s_if.tvalid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = ($urandom_range(0, 1) == 1);
        acc = 0;
        budget = 0;
        while (!acc && budget < 1000) begin
            @(negedge clk);
            acc = (s_if.tready === 1'b1);
            @(posedge clk);
            #1;
            budget++;
        end
        if (!acc) begin
            vectors++;
            errors++;
            $display("FAIL input_timeout: got tready_o=0 for 1000 cycles required acceptance of %h", d);
        end else if (is_pix) begin
            exp_q.push_back({last, d});
            if (lat_req) begin
                first_acc_cyc = cyc;
                lat_armed = 1;
                lat_req = 0;
            end
        end
    endtask

    // Upper header bits are filled with noise: only the low DIM_W bits size the frame.
    task automatic send_frame(input int unsigned x, input int unsigned y,
                              input logic [DATA_W-1:0] base, input bit rnd, input bit gaps);
        logic [DATA_W-1:0] hdr;
        logic [DATA_W-1:0] d;
        int unsigned total;
        total = x * y;
        hdr = DATA_W'($urandom);
        hdr[DIM_W-1:0] = DIM_W'(x);
        send_word(hdr, 0, 0, gaps);
        hdr = DATA_W'($urandom);
        hdr[DIM_W-1:0] = DIM_W'(y);
        send_word(hdr, 0, 0, gaps);
        for (int unsigned i = 0; i < total; i++) begin
            d = rnd ? DATA_W'($urandom) : base + DATA_W'(i);
            send_word(d, 1, i == total - 1, gaps);
        end
    endtask

    task automatic drain(input string name);
        int n;
        s_if.tvalid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d beats outstanding required 0", name, exp_q.size());
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 32'(m_if.tvalid), 32'h0);
        check("rst_tlast",  32'(m_if.tlast),  32'h0);
        check("rst_tdata",  32'(m_if.tdata),  32'h0);
        check("rst_tready", 32'(s_if.tready), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_tready", 32'(s_if.tready), 32'h1);

        // 4x2 frame with latency measured on the first pixel.
        mode = 0;
        lat_req = 1;
        send_frame(4, 2, 24'h000001, 0, 0);
        drain("frame4x2");
        check("first_latency", 32'(first_out_cyc - first_acc_cyc), 32'(STAGES - 1));

        mode = 1;
        send_frame(4, 2, 24'h000001, 0, 0);
        drain("backpressure");
        mode = 0;

        send_frame(2, 2, 24'h00000A, 0, 0);
        send_frame(3, 1, 24'h00000E, 0, 0);
        drain("back_to_back");

        send_frame(0, 5, 24'h000000, 0, 0);
        send_frame(1, 1, 24'hABCDEF, 0, 0);
        drain("zero_size");

        // Mid-frame reset: five pixels of a 4x4 frame, then a one-cycle reset.
        send_word(24'h000004, 0, 0, 0);
        send_word(24'h000004, 0, 0, 0);
        for (int unsigned i = 0; i < 5; i++) send_word(24'h300000 + 24'(i), 1, 0, 0);
        s_if.tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("midrst_tvalid", 32'(m_if.tvalid), 32'h0);
        check("midrst_tlast",  32'(m_if.tlast),  32'h0);
        check("midrst_tdata",  32'(m_if.tdata),  32'h0);
        check("midrst_tready", 32'(s_if.tready), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_release_tready", 32'(s_if.tready), 32'h1);
        send_word(24'h000001, 0, 0, 0);
        send_word(24'h000002, 0, 0, 0);
        send_word(24'h111111, 1, 0, 0);
        send_word(24'h222222, 1, 1, 0);
        drain("mid_reset");

        mode = 2;
        for (int k = 0; k < 8; k++) begin
            send_frame($urandom_range(1, 6), $urandom_range(1, 6), '0, 1, 1);
        end
        drain("random_frames");

        // Sustained random frame at full rate; ready must never drop.
        mode = 0;
        repeat (4) @(posedge clk);
        #1;
        chk_rdy = 1;
        send_frame(128, 128, '0, 1, 0);
        chk_rdy = 0;
        drain("sustained");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
